chnlnk_rdout_sched: RTL and testbench

Readout scheduler for the channel-link frame FSM. It counts L1A-matched events waiting in the sample buffer and releases them to the framer one at a time by driving the framer's L1A_BUF_MT input. For each event it latches the sample count and watches the framer's busy and last-word indications. It times out hung frames and reports sticky overflow and timeout errors to the status registers.

---
 rtl/chnlnk_rdout_sched.sv | 84 ++++++++
 tb/tb_chnlnk_rdout_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chnlnk_rdout_sched.sv
// chnlnk_rdout_sched: releases pending L1A-matched events to the framer one at a time, with watchdog and sticky errors
module chnlnk_rdout_sched #(
    parameter int CNT_W = 4,
    parameter int TMO   = 1023,
    parameter int GAP   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic             i_en,
    input  logic             i_clr_err,
    input  logic             i_l1a_match,
    input  logic [6:0]       i_samp_max,
    input  logic             i_frm_busy,
    input  logic             i_frm_last,
    output logic             o_l1a_buf_mt,
    output logic [6:0]       o_evt_samp,
    output logic [CNT_W-1:0] o_evt_pend,
    output logic             o_evt_done,
    output logic             o_ovfl,
    output logic             o_tmo_err,
    output logic [1:0]       o_sched_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2, S_GAP = 2'd3} state_t;
    state_t      r_state, w_nxt;
    logic [15:0] r_wdog;
    logic [3:0]  r_gap;
    logic        w_busy_ph, w_tmo, w_grant, w_retire, w_full;
    assign w_busy_ph     = (r_state == S_ARM) || (r_state == S_RUN);
    assign w_tmo         = w_busy_ph && (r_wdog == 16'(TMO));
    assign w_full        = (o_evt_pend == '1);
    assign o_sched_state = r_state;
    // next-state: grant in IDLE, framer handshake in ARM/RUN, watchdog overrides both
    always_comb begin
        w_nxt   = r_state;
        w_grant = 1'b0;
        case (r_state)
            S_IDLE: if (i_en && o_evt_pend != '0) begin
                w_nxt   = S_ARM;
                w_grant = 1'b1;
            end
            S_ARM:  w_nxt = w_tmo ? S_GAP : (i_frm_busy ? S_RUN : S_ARM);
            S_RUN:  w_nxt = (w_tmo || i_frm_last) ? S_GAP : S_RUN;
            S_GAP:  w_nxt = (r_gap == 4'(GAP - 1)) ? S_IDLE : S_GAP;
        endcase
        w_retire = w_busy_ph && (w_nxt == S_GAP);
    end
    // state, watchdog and gap counters
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state <= S_IDLE;
            r_wdog  <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nxt;
            r_wdog  <= w_grant ? '0 : (w_busy_ph ? r_wdog + 16'd1 : r_wdog);
            r_gap   <= (r_state == S_GAP && w_nxt == S_GAP) ? r_gap + 4'd1 : '0;
        end
    end
    // framer request, sample latch, done pulse and saturating pending count
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            o_l1a_buf_mt <= 1'b1;
            o_evt_samp   <= 7'd1;
            o_evt_pend   <= '0;
            o_evt_done   <= 1'b0;
        end else begin
            o_l1a_buf_mt <= (w_nxt != S_ARM);
            o_evt_samp   <= w_grant ? ((i_samp_max == 7'd0) ? 7'd1 : i_samp_max) : o_evt_samp;
            o_evt_done   <= w_retire;
            o_evt_pend   <= (i_l1a_match && !w_retire && !w_full) ? o_evt_pend + CNT_W'(1) :
                            (!i_l1a_match && w_retire) ? o_evt_pend - CNT_W'(1) : o_evt_pend;
        end
    end
    // sticky errors; a new error in the clear cycle stays set
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            o_ovfl    <= 1'b0;
            o_tmo_err <= 1'b0;
        end else begin
            o_ovfl    <= (i_l1a_match && !w_retire && w_full) || (o_ovfl && !i_clr_err);
            o_tmo_err <= w_tmo || (o_tmo_err && !i_clr_err);
        end
    end
endmodule

// File: tb/tb_chnlnk_rdout_sched.sv
// tb_chnlnk_rdout_sched: directed scenarios plus randomized run against a behavioural model
module tb_chnlnk_rdout_sched;
    localparam int TMO  = 100;
    localparam int GAP  = 2;
    localparam int PMAX = 15;

    logic       clk = 1'b0, rst_b = 1'b0, en = 1'b0, clr = 1'b0, l1a = 1'b0, busy = 1'b0, last = 1'b0;
    logic [6:0] smax = 7'd0;
    logic       mt, done, ovfl, tmo_err;
    logic [6:0] samp;
    logic [3:0] pend;
    logic [1:0] st;
    int         checks = 0, errors = 0;
    int         lowrun = 0, bc = 0;

    chnlnk_rdout_sched #(.CNT_W(4), .TMO(TMO), .GAP(GAP)) dut (
        .i_clk(clk), .i_rst_b(rst_b), .i_en(en), .i_clr_err(clr), .i_l1a_match(l1a),
        .i_samp_max(smax), .i_frm_busy(busy), .i_frm_last(last),
        .o_l1a_buf_mt(mt), .o_evt_samp(samp), .o_evt_pend(pend), .o_evt_done(done),
        .o_ovfl(ovfl), .o_tmo_err(tmo_err), .o_sched_state(st)
    );

    always #12 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {en, clr, l1a, busy, last} = '0;
        smax = 7'd0;
        lowrun = 0;
        bc = 0;
        rst_b = 1'b0;
        repeat (2) tick();
        rst_b = 1'b1;
    endtask

    // framer: busy two cycles after the request appears, LAST last_at cycles after busy (0 = never)
    task automatic framer_step(input int last_at);
        lowrun = mt ? 0 : lowrun + 1;
        last = 1'b0;
        if (busy) begin
            bc++;
            if (last_at > 0 && bc == last_at) last = 1'b1;
            if (last_at > 0 && bc > last_at) busy = 1'b0;
        end else if (lowrun == 3) begin
            busy = 1'b1;
            bc = 0;
        end
    endtask

    task automatic test_reset();
        {en, clr, busy, last} = '0;
        l1a = 1'b1;
        rst_b = 1'b0;
        repeat (3) tick();
        checks += 7;
        if (mt !== 1'b1)    begin errors++; $display("FAIL reset_mt got %b exp 1", mt); end
        if (samp !== 7'd1)  begin errors++; $display("FAIL reset_samp got %0d exp 1", samp); end
        if (pend !== 4'd0)  begin errors++; $display("FAIL reset_pend got %0d exp 0", pend); end
        if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        if (ovfl !== 1'b0)  begin errors++; $display("FAIL reset_ovfl got %b exp 0", ovfl); end
        if (tmo_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b exp 0", tmo_err); end
        if (st !== 2'd0)    begin errors++; $display("FAIL reset_state got %0d exp 0", st); end
        l1a = 1'b0;
        rst_b = 1'b1;
    endtask

    task automatic test_three_events();
        int peak = 0, dones = 0, runs = 0, run_len = 0, bad_run = 0, last_done = -1;
        logic [1:0] prev = 2'd0;
        do_reset();
        en = 1'b1;
        smax = 7'd8;
        for (int t = 0; t < 180; t++) begin
            if (int'(pend) > peak) peak = int'(pend);
            if (st == 2'd1 && prev != 2'd1) begin
                checks++;
                if (samp !== 7'd8) begin errors++; $display("FAIL three_samp got %0d exp 8", samp); end
                if (last_done >= 0) begin
                    checks++;
                    if (t - last_done != GAP + 1) begin
                        errors++; $display("FAIL three_gap got %0d exp %0d", t - last_done, GAP + 1);
                    end
                end
            end
            if (done) begin dones++; last_done = t; end
            if (!mt) run_len++;
            else if (run_len > 0) begin runs++; if (run_len != 3) bad_run++; run_len = 0; end
            prev = st;
            l1a = (t == 0 || t == 5 || t == 10);
            framer_step(20);
            tick();
        end
        checks += 5;
        if (peak != 3)     begin errors++; $display("FAIL three_peak got %0d exp 3", peak); end
        if (dones != 3)    begin errors++; $display("FAIL three_dones got %0d exp 3", dones); end
        if (pend !== 4'd0) begin errors++; $display("FAIL three_pend_end got %0d exp 0", pend); end
        if (runs != 3)     begin errors++; $display("FAIL three_req_count got %0d exp 3", runs); end
        if (bad_run != 0)  begin errors++; $display("FAIL three_req_len got %0d bad exp 0", bad_run); end
    endtask

    task automatic test_same_cycle();
        int n = 0;
        do_reset();
        l1a = 1'b1;
        repeat (2) tick();
        l1a = 1'b0;
        en = 1'b1;
        while (n < 100) begin
            framer_step(20);
            if (last) break;
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL same_wait_last got timeout exp last"); end
        l1a = 1'b1;
        tick();
        l1a = 1'b0;
        last = 1'b0;
        checks += 2;
        if (pend !== 4'd2) begin errors++; $display("FAIL same_pend got %0d exp 2", pend); end
        if (done !== 1'b1) begin errors++; $display("FAIL same_done got %b exp 1", done); end
        tick();
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL same_done_drop got %b exp 0", done); end
        if (pend !== 4'd2) begin errors++; $display("FAIL same_pend_after got %0d exp 2", pend); end
    endtask

    task automatic test_overflow();
        do_reset();
        l1a = 1'b1;
        repeat (15) tick();
        checks += 2;
        if (pend !== 4'd15) begin errors++; $display("FAIL ovf_pend15 got %0d exp 15", pend); end
        if (ovfl !== 1'b0)  begin errors++; $display("FAIL ovf_early got %b exp 0", ovfl); end
        tick();
        checks += 2;
        if (pend !== 4'd15) begin errors++; $display("FAIL ovf_pend_hold got %0d exp 15", pend); end
        if (ovfl !== 1'b1)  begin errors++; $display("FAIL ovf_set got %b exp 1", ovfl); end
        l1a = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks += 2;
        if (ovfl !== 1'b0)  begin errors++; $display("FAIL ovf_clear got %b exp 0", ovfl); end
        if (pend !== 4'd15) begin errors++; $display("FAIL ovf_pend_clr got %0d exp 15", pend); end
        l1a = 1'b1;
        clr = 1'b1;
        tick();
        {l1a, clr} = '0;
        checks++;
        if (ovfl !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovfl); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        l1a = 1'b1;
        repeat (2) tick();
        l1a = 1'b0;
        en = 1'b1;
        while (st != 2'd1 && n < 20) begin framer_step(0); tick(); n++; end
        checks++;
        if (st !== 2'd1) begin errors++; $display("FAIL tmo_wait_arm got %0d exp 1", st); end
        for (int j = 1; j <= TMO + GAP + 2; j++) begin
            framer_step(0);
            tick();
            if (j == TMO) begin
                checks += 2;
                if (st !== 2'd2)      begin errors++; $display("FAIL tmo_before_state got %0d exp 2", st); end
                if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_before_err got %b exp 0", tmo_err); end
            end
            if (j == TMO + 1) begin
                checks += 5;
                if (st !== 2'd3)      begin errors++; $display("FAIL tmo_gap_state got %0d exp 3", st); end
                if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", tmo_err); end
                if (done !== 1'b1)    begin errors++; $display("FAIL tmo_done got %b exp 1", done); end
                if (pend !== 4'd1)    begin errors++; $display("FAIL tmo_pend got %0d exp 1", pend); end
                if (mt !== 1'b1)      begin errors++; $display("FAIL tmo_mt got %b exp 1", mt); end
                busy = 1'b0;
            end
            if (j == TMO + GAP + 2) begin
                checks += 2;
                if (st !== 2'd1) begin errors++; $display("FAIL tmo_next_grant got %0d exp 1", st); end
                if (mt !== 1'b0) begin errors++; $display("FAIL tmo_next_mt got %b exp 0", mt); end
            end
        end
    endtask

    task automatic test_samp_min();
        int n = 0;
        do_reset();
        l1a = 1'b1;
        tick();
        l1a = 1'b0;
        en = 1'b1;
        while (st != 2'd1 && n < 20) begin framer_step(20); tick(); n++; end
        checks += 2;
        if (st !== 2'd1)   begin errors++; $display("FAIL samp_wait_arm got %0d exp 1", st); end
        if (samp !== 7'd1) begin errors++; $display("FAIL samp_min got %0d exp 1", samp); end
        n = 0;
        while (st != 2'd2 && n < 20) begin framer_step(20); tick(); n++; end
        smax = 7'd40;
        repeat (3) begin framer_step(20); tick(); end
        checks += 2;
        if (st !== 2'd2)   begin errors++; $display("FAIL samp_run_state got %0d exp 2", st); end
        if (samp !== 7'd1) begin errors++; $display("FAIL samp_hold got %0d exp 1", samp); end
    endtask

    task automatic test_reset_mid();
        int n = 0, seen = 0;
        do_reset();
        l1a = 1'b1;
        repeat (4) tick();
        l1a = 1'b0;
        en = 1'b1;
        while (st != 2'd2 && n < 20) begin framer_step(20); tick(); n++; end
        checks += 2;
        if (st !== 2'd2)   begin errors++; $display("FAIL rstmid_run got %0d exp 2", st); end
        if (pend !== 4'd4) begin errors++; $display("FAIL rstmid_pend got %0d exp 4", pend); end
        last = 1'b1;
        #5 rst_b = 1'b0;
        #1;
        checks += 7;
        if (mt !== 1'b1)      begin errors++; $display("FAIL rstmid_mt got %b exp 1", mt); end
        if (samp !== 7'd1)    begin errors++; $display("FAIL rstmid_samp got %0d exp 1", samp); end
        if (pend !== 4'd0)    begin errors++; $display("FAIL rstmid_pend0 got %0d exp 0", pend); end
        if (done !== 1'b0)    begin errors++; $display("FAIL rstmid_done got %b exp 0", done); end
        if (ovfl !== 1'b0)    begin errors++; $display("FAIL rstmid_ovfl got %b exp 0", ovfl); end
        if (tmo_err !== 1'b0) begin errors++; $display("FAIL rstmid_tmo got %b exp 0", tmo_err); end
        if (st !== 2'd0)      begin errors++; $display("FAIL rstmid_state got %0d exp 0", st); end
        repeat (3) begin tick(); if (done) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", seen); end
        {busy, last, en} = '0;
        rst_b = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] m_pend = 4'd0;
        logic [6:0] m_samp = 7'd1;
        logic [1:0] m_st = 2'd0;
        logic       m_mt = 1'b1, m_done = 1'b0, m_ovfl = 1'b0, m_tmo = 1'b0;
        int         m_cyc = 0, m_arm = 0, m_idle = 0, p, rdly = 0, rlen = 0;
        logic [1:0] ns;
        logic       to, ret, rhang = 1'b0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            last = 1'b0;
            if (busy) begin
                if (st == 2'd3 || st == 2'd0) busy = 1'b0;
                else if (rlen > 0) begin rlen--; if (rlen == 0 && !rhang) last = 1'b1; end
            end else if (!mt) begin
                if (rdly == 0) begin
                    busy = 1'b1;
                    rlen = $urandom_range(15, 2);
                    rhang = ($urandom % 16 == 0);
                    rdly = $urandom_range(3, 0);
                end else rdly--;
            end
            if ($urandom % 40 == 0) last = 1'b1;
            if ($urandom % 50 == 0) en = ~en;
            l1a = ($urandom % 4 == 0);
            clr = ($urandom % 64 == 0);
            smax = ($urandom % 8 == 0) ? 7'd0 : 7'($urandom % 128);
            // reference: grant when idle with work, retire on LAST in RUN or when TMO cycles have elapsed since grant
            to = (m_st == 2'd1 || m_st == 2'd2) && (m_cyc - m_arm == TMO);
            ret = 1'b0;
            ns = m_st;
            if (m_st == 2'd0) begin
                if (en && m_pend != 0) begin ns = 2'd1; m_arm = m_cyc + 1; m_samp = (smax == 0) ? 7'd1 : smax; end
            end else if (m_st == 2'd3) begin
                if (m_cyc + 1 == m_idle) ns = 2'd0;
            end else if (to || (m_st == 2'd2 && last)) begin
                ns = 2'd3; ret = 1'b1; m_idle = m_cyc + 1 + GAP;
            end else if (m_st == 2'd1 && busy) ns = 2'd2;
            m_ovfl = (l1a && !ret && int'(m_pend) == PMAX) || (m_ovfl && !clr);
            m_tmo = to || (m_tmo && !clr);
            p = int'(m_pend) + int'(l1a) - int'(ret);
            m_pend = 4'((p > PMAX) ? PMAX : p);
            m_done = ret;
            m_mt = (ns != 2'd1);
            m_st = ns;
            m_cyc++;
            tick();
            checks += 7;
            if (st !== m_st)      begin errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", i, st, m_st); end
            if (mt !== m_mt)      begin errors++; $display("FAIL rnd_mt cyc %0d got %b exp %b", i, mt, m_mt); end
            if (samp !== m_samp)  begin errors++; $display("FAIL rnd_samp cyc %0d got %0d exp %0d", i, samp, m_samp); end
            if (pend !== m_pend)  begin errors++; $display("FAIL rnd_pend cyc %0d got %0d exp %0d", i, pend, m_pend); end
            if (done !== m_done)  begin errors++; $display("FAIL rnd_done cyc %0d got %b exp %b", i, done, m_done); end
            if (ovfl !== m_ovfl)  begin errors++; $display("FAIL rnd_ovfl cyc %0d got %b exp %b", i, ovfl, m_ovfl); end
            if (tmo_err !== m_tmo) begin errors++; $display("FAIL rnd_tmo cyc %0d got %b exp %b", i, tmo_err, m_tmo); end
        end
    endtask

    initial begin
        test_reset();
        test_three_events();
        test_same_cycle();
        test_overflow();
        test_timeout();
        test_samp_min();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
